// File: rtl/bq_sample_prep.sv
// Purpose : pad sample capture, decimate-by-accumulation and single-entry hand-off to the biquad.
// Latency : DECIM=1 -> x_valid_o rises 3 bq_clk_i edges after the first edge that samples the strobe high.
// Backpr. : one holding register; a result arriving while it is full and x_ready_i=0 is dropped (overrun_o).
//
// Ports:
//   bq_clk_i      filter clock, all state lives on it
//   nreset        asynchronous active-low reset
//   enable_i      capture enable (quasi-static)
//   clr_i         synchronous clear of accumulator, phase and overrun
//   pad_data_i    raw 8-bit pad sample (not synchronised; must be stable around the strobe)
//   pad_strobe_i  asynchronous strobe, rising edge marks a new sample
//   x_o           16-bit left-aligned signed decimated sample
//   x_valid_o     x_o holds an unconsumed sample
//   x_ready_i     filter takes x_o this cycle
//   overrun_o     sticky flag, a decimated result was dropped
//   phase_o       samples accumulated so far in the current group
//
// Build option: define BQ_SAMPLE_PREP_OFFSET_BIN_EN when the pads deliver offset-binary samples.

module bq_sample_prep #(
    parameter int DECIM_LOG2 = 0
) (
    input  logic        bq_clk_i,
    input  logic        nreset,
    input  logic        enable_i,
    input  logic        clr_i,
    input  logic [7:0]  pad_data_i,
    input  logic        pad_strobe_i,
    output logic [15:0] x_o,
    output logic        x_valid_o,
    input  logic        x_ready_i,
    output logic        overrun_o,
    output logic [7:0]  phase_o
);

    // Accumulator is wide enough for DECIM full-scale samples; the left
    // shift then puts the accumulator MSB at bit 15 whatever DECIM_LOG2 is.
    localparam int         ACC_W      = 8 + DECIM_LOG2;
    localparam int         OUT_SHIFT  = 8 - DECIM_LOG2;
    localparam logic [7:0] PHASE_LAST = 8'((1 << DECIM_LOG2) - 1);

    // ------------------------------------------------------------------
    // Strobe synchroniser: s1/s2 resolve metastability, s3 is the delayed
    // copy for rising-edge detection.
    // ------------------------------------------------------------------
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;
    logic strobe_edge;

    always_comb begin
        s1_d        = pad_strobe_i;
        s2_d        = s1_q;
        s3_d        = s2_q;
        strobe_edge = s2_q & ~s3_q;
    end

    // ------------------------------------------------------------------
    // Sample capture. The pad data bus is sampled directly: the edge
    // arrives two clocks after the strobe, by which time the bus has been
    // stable for several cycles.
    // ------------------------------------------------------------------
    logic [7:0] samp_q, samp_d;
    logic       samp_vld_q, samp_vld_d;

    always_comb begin
        samp_d     = samp_q;
        samp_vld_d = 1'b0;
        if (strobe_edge && enable_i) begin
            samp_d     = pad_data_i;
            samp_vld_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sample conversion to two's complement, then sign-extension to the
    // accumulator width.
    // ------------------------------------------------------------------
    logic signed [7:0]       samp_s;
    logic signed [ACC_W-1:0] samp_ext;

    always_comb begin
`ifdef BQ_SAMPLE_PREP_OFFSET_BIN_EN
        // Offset binary: flipping the MSB recentres 0x80 on zero.
        samp_s = {~samp_q[7], samp_q[6:0]};
`else
        samp_s = samp_q;
`endif
        samp_ext = ACC_W'(samp_s);
    end

    // ------------------------------------------------------------------
    // Accumulate-and-dump
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] acc_sum;
    logic [7:0]              phase_q, phase_d;
    logic                    res_vld;
    logic [15:0]             res_fmt;

    always_comb begin
        acc_sum = acc_q + samp_ext;
        // Sign-extend to 16 bits first; the shift then discards exactly the
        // extension bits and leaves the sum left-aligned.
        res_fmt = 16'(acc_sum) << OUT_SHIFT;

        acc_d   = acc_q;
        phase_d = phase_q;
        res_vld = 1'b0;

        if (!enable_i) begin
            // Disabled: hold the group empty so re-enabling starts cleanly,
            // and drop any sample still in flight.
            acc_d   = '0;
            phase_d = '0;
        end else if (samp_vld_q) begin
            if (phase_q == PHASE_LAST) begin
                res_vld = 1'b1;
                acc_d   = '0;
                phase_d = '0;
            end else begin
                acc_d   = acc_sum;
                phase_d = phase_q + 8'd1;
            end
        end

        // Clear wins over a result completing in the same cycle.
        if (clr_i) begin
            acc_d   = '0;
            phase_d = '0;
            res_vld = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Single-entry output register with drop-on-full.
    // ------------------------------------------------------------------
    logic [15:0] x_q, x_d;
    logic        x_vld_q, x_vld_d;
    logic        ovr_q, ovr_d;

    always_comb begin
        x_d     = x_q;
        x_vld_d = x_vld_q;
        ovr_d   = ovr_q;

        if (res_vld) begin
            // Load also when the current word is consumed in this cycle,
            // so a steady stream never loses a sample to the hand-off.
            if (!x_vld_q || x_ready_i) begin
                x_d     = res_fmt;
                x_vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (x_ready_i) begin
            // Data is left in place; only the valid flag drops.
            x_vld_d = 1'b0;
        end

        if (clr_i) begin
            ovr_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge bq_clk_i or negedge nreset) begin
        if (!nreset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            samp_q     <= '0;
            samp_vld_q <= 1'b0;
            acc_q      <= '0;
            phase_q    <= '0;
            x_q        <= '0;
            x_vld_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            samp_q     <= samp_d;
            samp_vld_q <= samp_vld_d;
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            x_q        <= x_d;
            x_vld_q    <= x_vld_d;
            ovr_q      <= ovr_d;
        end
    end

    assign x_o       = x_q;
    assign x_valid_o = x_vld_q;
    assign overrun_o = ovr_q;
    assign phase_o   = phase_q;

endmodule

// File: tb/tb_bq_sample_prep.sv
// Bench for bq_sample_prep: three instances (DECIM_LOG2 = 0, 1, 2) share one
// stimulus stream; a cycle-level reference model follows the behavioural
// rules for each instance and is checked every cycle, with literal checks
// pinning the model at the interesting points.

module tb_bq_sample_prep;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       nreset;
    logic       enable;
    logic       clr;
    logic [7:0] pad_data;
    logic       pad_strobe;
    logic       x_ready;

    logic [15:0] d_xo  [NI];
    logic        d_v   [NI];
    logic        d_ovr [NI];
    logic [7:0]  d_ph  [NI];

    always #5 clk = ~clk;

    bq_sample_prep #(.DECIM_LOG2(0)) u_d0 (
        .bq_clk_i(clk), .nreset(nreset), .enable_i(enable), .clr_i(clr),
        .pad_data_i(pad_data), .pad_strobe_i(pad_strobe),
        .x_o(d_xo[0]), .x_valid_o(d_v[0]), .x_ready_i(x_ready),
        .overrun_o(d_ovr[0]), .phase_o(d_ph[0]));

    bq_sample_prep #(.DECIM_LOG2(1)) u_d1 (
        .bq_clk_i(clk), .nreset(nreset), .enable_i(enable), .clr_i(clr),
        .pad_data_i(pad_data), .pad_strobe_i(pad_strobe),
        .x_o(d_xo[1]), .x_valid_o(d_v[1]), .x_ready_i(x_ready),
        .overrun_o(d_ovr[1]), .phase_o(d_ph[1]));

    bq_sample_prep #(.DECIM_LOG2(2)) u_d2 (
        .bq_clk_i(clk), .nreset(nreset), .enable_i(enable), .clr_i(clr),
        .pad_data_i(pad_data), .pad_strobe_i(pad_strobe),
        .x_o(d_xo[2]), .x_valid_o(d_v[2]), .x_ready_i(x_ready),
        .overrun_o(d_ovr[2]), .phase_o(d_ph[2]));

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int conv(input logic [7:0] d);
`ifdef BQ_SAMPLE_PREP_OFFSET_BIN_EN
        return int'(d) - 128;
`else
        return (d >= 8'd128) ? int'(d) - 256 : int'(d);
`endif
    endfunction

    // ---------------- reference model ----------------
    // Inputs as seen at each rising edge.
    logic       smp_rst = 1'b0;
    logic       smp_str = 1'b0;
    logic [7:0] smp_dat = '0;
    logic       smp_en  = 1'b0;
    logic       smp_clr = 1'b0;
    logic       smp_rdy = 1'b0;

    always @(posedge clk) begin
        smp_rst <= nreset;
        smp_str <= pad_strobe;
        smp_dat <= pad_data;
        smp_en  <= enable;
        smp_clr <= clr;
        smp_rdy <= x_ready;
    end

    int  m_acc [NI];
    int  m_ph  [NI];
    int  m_xo  [NI];
    bit  m_v   [NI];
    bit  m_ovr [NI];
    bit  st_h  [5];   // st_h[j] = strobe level seen j edges ago
    bit  en_prev;
    logic [7:0] d_prev;
    bit  ev;
    int  mres;
    bit  mrv;

    // A strobe first seen high at edge E is summed at edge E+3 using the
    // pad data present at edge E+2; enable must be high at both edges.
    always @(negedge clk) begin
        if (!smp_rst) begin
            for (int i = 0; i < NI; i++) begin
                m_acc[i] = 0; m_ph[i] = 0; m_xo[i] = 0; m_v[i] = 1'b0; m_ovr[i] = 1'b0;
            end
            for (int j = 0; j < 5; j++) st_h[j] = 1'b0;
            en_prev = 1'b0;
            d_prev  = '0;
        end else begin
            for (int j = 4; j > 0; j--) st_h[j] = st_h[j-1];
            st_h[0] = smp_str;
            ev = st_h[3] && !st_h[4] && en_prev && smp_en;
            for (int i = 0; i < NI; i++) begin
                mrv = 1'b0;
                mres = 0;
                if (!smp_en) begin
                    m_acc[i] = 0; m_ph[i] = 0;
                end else if (ev) begin
                    if (m_ph[i] == (1 << i) - 1) begin
                        mres = m_acc[i] + conv(d_prev);
                        mrv = 1'b1;
                        m_acc[i] = 0; m_ph[i] = 0;
                    end else begin
                        m_acc[i] += conv(d_prev);
                        m_ph[i]++;
                    end
                end
                if (smp_clr) begin
                    m_acc[i] = 0; m_ph[i] = 0; m_ovr[i] = 1'b0; mrv = 1'b0;
                end
                if (mrv) begin
                    if (!m_v[i] || smp_rdy) begin
                        m_xo[i] = (mres << (8 - i)) & 32'hFFFF;
                        m_v[i]  = 1'b1;
                    end else begin
                        m_ovr[i] = 1'b1;
                    end
                end else if (smp_rdy) begin
                    m_v[i] = 1'b0;
                end
            end
            en_prev = smp_en;
            d_prev  = smp_dat;
        end
        if (cmp_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("x_o[d%0d]", i),       32'(d_xo[i]),  32'(m_xo[i]));
                chk($sformatf("x_valid_o[d%0d]", i), 32'(d_v[i]),   32'(m_v[i]));
                chk($sformatf("overrun_o[d%0d]", i), 32'(d_ovr[i]), 32'(m_ovr[i]));
                chk($sformatf("phase_o[d%0d]", i),   32'(d_ph[i]),  32'(m_ph[i]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // rise: present data, raise strobe, return at the falling clock after E+2.
    task automatic rise(input logic [7:0] d);
        @(negedge clk) pad_data = d;
        @(negedge clk) pad_strobe = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic fall();
        pad_strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Complete sample; the result (if any) has landed when this returns.
    task automatic send(input logic [7:0] d);
        rise(d);
        @(negedge clk);
        fall();
    endtask

    // Drain the output register and empty every accumulator.
    task automatic flush();
        @(negedge clk) begin x_ready = 1'b1; clr = 1'b1; end
        @(negedge clk) clr = 1'b0;
        @(negedge clk) x_ready = 1'b0;
    endtask

    logic [7:0] dec_samp [4];
    int         dec_ph   [4];
    logic [15:0] neg_exp_80;
    logic [15:0] neg_exp_00;

    initial begin
        nreset = 1'b0; enable = 1'b1; clr = 1'b0;
        pad_data = '0; pad_strobe = 1'b0; x_ready = 1'b0;
        dec_samp = '{8'h10, 8'h20, 8'h30, 8'h40};
        dec_ph   = '{1, 2, 3, 0};
`ifdef BQ_SAMPLE_PREP_OFFSET_BIN_EN
        neg_exp_80 = 16'h0000;
        neg_exp_00 = 16'h8000;
`else
        neg_exp_80 = 16'h8000;
        neg_exp_00 = 16'h0000;
`endif

        repeat (3) @(negedge clk);
        chk("rst x_o", 32'(d_xo[0]), 32'h0);
        chk("rst x_valid_o", 32'(d_v[0]), 32'h0);
        chk("rst overrun_o", 32'(d_ovr[0]), 32'h0);
        chk("rst phase_o", 32'(d_ph[2]), 32'h0);
        nreset = 1'b1;
        @(negedge clk) cmp_en = 1'b1;

        // Mid-stream asynchronous reset
        send(8'h11);
        chk("pre-rst x_o", 32'(d_xo[0]), 32'h1100);
        chk("pre-rst phase d2", 32'(d_ph[2]), 32'd1);
        @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        chk("async rst x_o", 32'(d_xo[0]), 32'h0);
        chk("async rst x_valid_o", 32'(d_v[0]), 32'h0);
        chk("async rst phase d2", 32'(d_ph[2]), 32'h0);
        @(negedge clk) nreset = 1'b1;

        // Latency, DECIM=1
        rise(8'h5A);
        chk("lat E+2 x_valid_o", 32'(d_v[0]), 32'h0);
        @(negedge clk);
        chk("lat E+3 x_valid_o", 32'(d_v[0]), 32'h1);
        chk("lat E+3 x_o", 32'(d_xo[0]), 32'h5A00);
        fall();
        flush();

        // Decimation by 4
        for (int k = 0; k < 4; k++) begin
            send(dec_samp[k]);
            chk($sformatf("dec phase %0d", k), 32'(d_ph[2]), 32'(dec_ph[k]));
        end
        chk("dec x_o", 32'(d_xo[2]), 32'h2800);
        chk("dec x_valid_o", 32'(d_v[2]), 32'h1);
        flush();

        // Sign handling, decimation by 2
        x_ready = 1'b1;
        send(8'h80);
        send(8'h80);
        chk("neg 0x80 x_o", 32'(d_xo[1]), 32'(neg_exp_80));
        send(8'h00);
        send(8'h00);
        chk("neg 0x00 x_o", 32'(d_xo[1]), 32'(neg_exp_00));
        flush();

        // Backpressure and overrun
        send(8'h11);
        chk("bp first x_o", 32'(d_xo[0]), 32'h1100);
        chk("bp first overrun", 32'(d_ovr[0]), 32'h0);
        send(8'h22);
        chk("bp drop x_o", 32'(d_xo[0]), 32'h1100);
        chk("bp drop overrun", 32'(d_ovr[0]), 32'h1);
        rise(8'h33);
        x_ready = 1'b1;
        @(negedge clk);
        chk("bp reload x_o", 32'(d_xo[0]), 32'h3300);
        chk("bp reload x_valid_o", 32'(d_v[0]), 32'h1);
        x_ready = 1'b0;
        fall();
        chk("bp sticky overrun", 32'(d_ovr[0]), 32'h1);
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        chk("bp clr overrun", 32'(d_ovr[0]), 32'h0);
        flush();

        // Enable gating
        x_ready = 1'b1;
        send(8'h01);
        send(8'h02);
        @(negedge clk) enable = 1'b0;
        send(8'h7F);
        chk("dis phase d2", 32'(d_ph[2]), 32'h0);
        @(negedge clk) enable = 1'b1;
        send(8'h04);
        send(8'h08);
        send(8'h10);
        send(8'h20);
        chk("en x_o", 32'(d_xo[2]), 32'h0F00);

        // Clear coincident with the completing accumulate
        send(8'h01);
        send(8'h01);
        send(8'h01);
        chk("clr pre phase d2", 32'(d_ph[2]), 32'd3);
        rise(8'h01);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr x_valid_o d2", 32'(d_v[2]), 32'h0);
        chk("clr phase d2", 32'(d_ph[2]), 32'h0);
        chk("clr x_o held d2", 32'(d_xo[2]), 32'h0F00);
        fall();

        repeat (5) @(negedge clk);
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bq_sample_prep.md
Name: bq_sample_prep

Overview:
- Upstream input stage for the bqmain biquad filter: captures 8-bit parallel samples from the user IO pads on an asynchronous pad strobe.
- Decimates by accumulate-and-dump and presents 16-bit left-aligned samples to the filter input over a valid/ready handshake.
- Single-entry output holding register; a sticky overrun flag records any result dropped because the filter did not consume in time.

Parameters:
- DECIM_LOG2, 0, log2 of the decimation factor (legal 0..8); DECIM = 2**DECIM_LOG2 samples summed per output.

Ports:
- bq_clk_i  input  1  filter clock; all logic is on this clock.
- nreset  input  1  asynchronous reset, active-low.
- enable_i  input  1  capture enable (quasi-static, from the Wishbone register).
- clr_i  input  1  synchronous clear pulse: accumulator, phase counter, overrun.
- pad_data_i  input  8  raw pad sample.
- pad_strobe_i  input  1  asynchronous sample strobe; rising edge = new sample.
- x_o  output  16  decimated sample, signed two's complement, left-aligned.
- x_valid_o  output  1  x_o holds an unconsumed sample.
- x_ready_i  input  1  filter accepts x_o this cycle.
- overrun_o  output  1  sticky: a decimated result was dropped.
- phase_o  output  8  current accumulation count, zero-extended.

Behaviour:
- Reset (nreset=0, async): sync chain, samp_q, samp_vld, accumulator, phase counter, x_o=0, x_valid_o=0, overrun_o=0, phase_o=0.
- Strobe sync: 3-flop chain s1->s2->s3; edge = s2 & ~s3. Strobe high first sampled at edge E -> samp_q captured at E+2.
- pad_data_i is not synchronised. Constraint: it must be stable from 1 cycle before the strobe rise to 4 cycles after. pad_data_i is registered directly into samp_q when edge=1; samp_vld pulses for 1 cycle.
- Sample conversion: 8-bit value s (see Optional Feature), sign-extended to 8+DECIM_LOG2 bits.
- Accumulate (cycle after samp_vld):
  - phase < DECIM-1: acc += s; phase++.
  - phase == DECIM-1: result = acc + s; acc=0; phase=0; offer result to the output register.
- Output format: x_o = result << (8-DECIM_LOG2), so full scale always sits in bits 15:8. DECIM_LOG2=0 gives x_o = {s, 8'h00}.
- End-to-end latency, DECIM=1: x_valid_o visible after edge E+3.
- Output register (single entry):
  - Load when empty, or full and x_ready_i=1 in the same cycle; x_valid_o=1.
  - Full and x_ready_i=0: result dropped, overrun_o set, x_o unchanged.
  - x_ready_i=1 with no new result: x_valid_o=0; x_o keeps its last value.
  - x_o stable while x_valid_o=1 and x_ready_i=0.
- enable_i=0: edges ignored; acc and phase held at 0; pending samp_vld discarded; output register still drains normally.
- enable_i 0->1: accumulation starts at phase 0 with the next edge.
- clr_i=1: acc=0, phase=0, overrun_o=0. A result completing in the same cycle is discarded (clr wins). Output register unaffected.
- Strobe pulses shorter than 1 clock may be missed; back-to-back edges need ≥2 low cycles between them.

Optional Feature:
- Macro BQ_SAMPLE_PREP_OFFSET_BIN_EN.
- Defined: pad_data_i is offset-binary; s = {~pad_data_i[7], pad_data_i[6:0]} (0x80 -> 0, 0x00 -> -128, 0xFF -> +127).
- Undefined: pad_data_i is already two's complement; s = pad_data_i.

Test Plan:
- Reset/latency: DECIM_LOG2=0, macro off; assert nreset=0 mid-stream -> all outputs 0 immediately. Release, strobe with pad_data_i=0x5A, x_ready_i=0 -> x_valid_o=1 after E+3, x_o=0x5A00.
- Decimation: DECIM_LOG2=2, samples 0x10,0x20,0x30,0x40 -> one result after the 4th, x_o=(0xA0<<6)=0x2800; phase_o sequence 1,2,3,0.
- Negative/sign: DECIM_LOG2=1, samples 0x80,0x80 -> sum -256 in 9 bits -> x_o=0x8000. Macro on, samples 0x00,0x00 -> x_o=0x8000.
- Backpressure/overrun: DECIM_LOG2=0, x_ready_i=0, two samples 0x11 then 0x22 -> x_o stays 0x1100, overrun_o=1. Raise x_ready_i in the cycle a third result (0x33) lands -> x_o=0x3300, x_valid_o stays 1. clr_i -> overrun_o=0.
- Enable/clear: DECIM_LOG2=2, 2 samples then enable_i=0, then 4 samples with enable_i=1 -> only the last 4 are summed. clr_i coincident with the 4th-sample accumulate -> no x_valid_o, phase_o=0.
